// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host transmitter and its line filter:
//   - ps2_state_t : transmitter FSM state encoding
//   - DEF_*       : default cycle constants (50 MHz system clock)
//   - CMD_*       : common host-to-device PS/2 command bytes
//   - odd_parity  : parity bit that makes {parity, byte} odd
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INHIBIT,
        START,
        BITS,
        STOP,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR
    } ps2_state_t;

    localparam int unsigned DEF_INHIBIT_CYCLES = 5000;     // 100 us
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1000000;  // 20 ms
    localparam int unsigned DEF_FILTER_LEN     = 8;

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] CMD_RESEND = 8'hFE;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter
// Input conditioning for the PS/2 clock and data pins.
//   sysclk_buf  in   system clock
//   reset       in   synchronous, active-high
//   clk_raw     in   raw PS/2 clock pin (asynchronous)
//   data_raw    in   raw PS/2 data pin (asynchronous)
//   clk_filt    out  synchronized, glitch-filtered clock level
//   clk_fall    out  1-cycle pulse on a filtered 1->0 clock transition
//   data_sync   out  synchronized data level
// A new clock level is accepted only after FILTER_LEN consecutive
// synchronized samples disagree with the current filtered level.
// ---------------------------------------------------------------------------
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = DEF_FILTER_LEN
) (
    input  logic sysclk_buf,
    input  logic reset,
    input  logic clk_raw,
    input  logic data_raw,
    output logic clk_filt,
    output logic clk_fall,
    output logic data_sync
);

    localparam int unsigned CW = $clog2(FILTER_LEN) + 1;

    logic [1:0]    clk_meta;
    logic [1:0]    data_meta;
    logic [CW-1:0] cnt;

    always_ff @(posedge sysclk_buf) begin
        if (reset) begin
            clk_meta  <= '1;
            data_meta <= '1;
            clk_filt  <= 1'b1;
            clk_fall  <= 1'b0;
            cnt       <= '0;
        end else begin
            clk_meta  <= {clk_meta[0], clk_raw};
            data_meta <= {data_meta[0], data_raw};
            clk_fall  <= 1'b0;
            if (clk_meta[1] == clk_filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_meta[1];
                // old filtered level 1 means this change is a falling edge
                clk_fall <= clk_filt;
                cnt      <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign data_sync = data_meta[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter: sends one command byte to a mouse or
// keyboard through low-only output enables (pad: pin = oe ? 0 : 'z).
//   sysclk_buf   in   clock, 50 MHz
//   reset        in   synchronous, active-high
//   tx_data      in   command byte, LSB first on the wire
//   tx_valid     in   request, accepted when tx_valid & tx_ready
//   tx_ready     out  high only in IDLE
//   tx_done      out  1-cycle pulse: frame sent and ACKed
//   tx_error     out  1-cycle pulse: timeout or missing ACK
//   ps2_clk_in   in   raw PS/2 clock pin
//   ps2_data_in  in   raw PS/2 data pin
//   ps2_clk_oe   out  1 = pull clock low
//   ps2_data_oe  out  1 = pull data low
//   busy         out  high in every state except IDLE
// Optional build macro PS2_TX_RETRY_EN: up to two automatic retries of a
// failed frame before tx_error is reported.
// ---------------------------------------------------------------------------
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned FILTER_LEN     = DEF_FILTER_LEN
) (
    input  logic       sysclk_buf,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy
);

    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ?
                                      TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    ps2_state_t       state;
    logic [8:0]       shreg;
    logic [3:0]       bitcnt;
    logic [CNT_W-1:0] cnt;
    logic             ack_bit;
    logic             clk_filt;
    logic             clk_fall;
    logic             data_sync;
    logic             last_try;

`ifdef PS2_TX_RETRY_EN
    logic [1:0] retry_cnt;
    assign last_try = (retry_cnt == 2'd2);
`else
    assign last_try = 1'b1;
`endif

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .sysclk_buf (sysclk_buf),
        .reset      (reset),
        .clk_raw    (ps2_clk_in),
        .data_raw   (ps2_data_in),
        .clk_filt   (clk_filt),
        .clk_fall   (clk_fall),
        .data_sync  (data_sync)
    );

    // shreg is indexed by bitcnt rather than shifted, so it still holds the
    // latched byte when a retry restarts the frame.
    always_ff @(posedge sysclk_buf) begin
        if (reset) begin
            state       <= IDLE;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            shreg       <= '0;
            bitcnt      <= '0;
            cnt         <= '0;
            ack_bit     <= 1'b1;
`ifdef PS2_TX_RETRY_EN
            retry_cnt   <= '0;
`endif
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shreg      <= {odd_parity(tx_data), tx_data};
                        cnt        <= '0;
                        ps2_clk_oe <= 1'b1;
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= INHIBIT;
`ifdef PS2_TX_RETRY_EN
                        retry_cnt  <= '0;
`endif
                    end
                end

                INHIBIT: begin
                    if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                        ps2_clk_oe <= 1'b0;
                        cnt        <= '0;
                        bitcnt     <= '0;
                        state      <= START;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        // start bit appears during the final inhibit cycle
                        if (cnt == CNT_W'(INHIBIT_CYCLES - 2)) begin
                            ps2_data_oe <= 1'b1;
                        end
                    end
                end

                START, BITS, STOP, ACK, WAIT_IDLE: begin
                    if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_error    <= last_try;
                        state       <= ERR;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        case (state)
                            START: begin
                                if (clk_fall) begin
                                    ps2_data_oe <= ~shreg[0];
                                    bitcnt      <= 4'd1;
                                    state       <= BITS;
                                end
                            end
                            BITS: begin
                                if (clk_fall) begin
                                    if (bitcnt == 4'd9) begin
                                        ps2_data_oe <= 1'b0;  // stop bit
                                        state       <= STOP;
                                    end else begin
                                        ps2_data_oe <= ~shreg[bitcnt];
                                        bitcnt      <= bitcnt + 4'd1;
                                    end
                                end
                            end
                            STOP: begin
                                if (clk_fall) begin
                                    ack_bit <= data_sync;
                                    state   <= ACK;
                                end
                            end
                            ACK: begin
                                if (ack_bit) begin
                                    tx_error <= last_try;
                                    state    <= ERR;
                                end else begin
                                    state <= WAIT_IDLE;
                                end
                            end
                            WAIT_IDLE: begin
                                if (clk_filt && data_sync) begin
                                    tx_done <= 1'b1;
                                    state   <= DONE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                DONE: begin
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end

                ERR: begin
`ifdef PS2_TX_RETRY_EN
                    if (!last_try) begin
                        retry_cnt  <= retry_cnt + 2'd1;
                        cnt        <= '0;
                        ps2_clk_oe <= 1'b1;
                        state      <= INHIBIT;
                    end else begin
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
`else
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
`endif
                end

                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    tx_ready    <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned INH  = 200;
    localparam int unsigned TO   = 3000;
    localparam int unsigned HALF = 40;
`ifdef PS2_TX_RETRY_EN
    localparam int TRIES = 3;
`else
    localparam int TRIES = 1;
`endif

    localparam int M_NORMAL = 0, M_NOCLK = 1, M_NOACK = 2, M_ABORT = 3, M_GLITCH = 4;
    localparam int R_DONE = 1, R_ERR = 2;

    logic       sysclk_buf = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error, busy;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #10 sysclk_buf = ~sysclk_buf;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO),
        .FILTER_LEN     (8)
    ) dut (
        .sysclk_buf  (sysclk_buf),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy)
    );

    int         checks = 0;
    int         errors = 0;
    logic [9:0] exp_frame[$];
    int         exp_res[$];
    int         mode = M_NORMAL;
    bit         dev_busy = 1'b0;
    int         dev_falls = 0;
    int         cyc = 0;
    int         accepts = 0;
    int         pending = 0;
    bit         chk_to = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk_buf);
        #1;
    endtask

    initial forever begin
        @(posedge sysclk_buf);
        cyc++;
    end

    // Monitor: accepts, inhibit timing and result pulses against the scoreboard.
    initial begin
        logic prev_oe;
        int   inh_len, start_cyc, code;
        prev_oe = 1'b0;
        inh_len = 0;
        start_cyc = 0;
        forever begin
            @(negedge sysclk_buf);
            if (reset) begin
                pending = 0;
                inh_len = 0;
                prev_oe = 1'b0;
            end else begin
                if (tx_valid && tx_ready) begin
                    check("accept_when_idle", pending, 0);
                    pending++;
                    accepts++;
                end
                if (ps2_clk_oe) begin
                    inh_len++;
                end else if (prev_oe) begin
                    check("inhibit_len", inh_len, INH);
                    check("start_bit_oe", 32'(ps2_data_oe), 1);
                    start_cyc = cyc;
                    inh_len = 0;
                end
                prev_oe = ps2_clk_oe;
                if (tx_done || tx_error) begin
                    code = tx_done ? R_DONE : R_ERR;
                    if (tx_done && tx_error) code = 3;
                    check("oe_released_at_pulse", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
                    check("one_outstanding", pending, 1);
                    pending--;
                    if (chk_to && tx_error) check("timeout_cycles", cyc - start_cyc, TO);
                    if (exp_res.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse: got code %0d expected none", code);
                    end else begin
                        check("result", code, exp_res.pop_front());
                    end
                end
            end
        end
    end

    // Device model: generates the clock after the host start bit,
    // samples data on rising edges and ACKs unless told otherwise.
    initial begin
        logic [9:0] cap;
        bit         aborted;
        cap = '0;
        forever begin
            dev_busy = 1'b0;
            while (!ps2_clk_oe) tick(1);
            while (ps2_clk_oe) tick(1);
            if (!ps2_data_oe || mode == M_NOCLK) continue;
            dev_busy = 1'b1;
            aborted = 1'b0;
            tick(50);
            for (int i = 1; i <= 11; i++) begin
                dev_clk = 1'b0;
                dev_falls = i;
                tick(HALF);
                if (mode == M_ABORT && i == 4) begin
                    dev_clk = 1'b1;
                    aborted = 1'b1;
                    break;
                end
                dev_clk = 1'b1;
                if (i <= 10) cap[i-1] = ps2_data_in;
                if (i == 10 && mode != M_NOACK) dev_data = 1'b0;
                if (i == 11) dev_data = 1'b1;
                if (mode == M_GLITCH && i == 2) begin
                    tick(15);
                    dev_clk = 1'b0;
                    tick(3);
                    dev_clk = 1'b1;
                    tick(HALF - 18);
                end else begin
                    tick(HALF);
                end
            end
            if (!aborted) begin
                if (exp_frame.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got 0x%0h expected none", cap);
                end else begin
                    check("frame_bits", 32'(cap), 32'(exp_frame.pop_front()));
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic [9:0] frame, input int nframes, input int res);
        int n;
        for (int k = 0; k < nframes; k++) exp_frame.push_back(frame);
        if (res != 0) exp_res.push_back(res);
        n = 0;
        while (!tx_ready && n < 1000) begin
            tick(1);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL ready_wait: got tx_ready 0 expected 1");
        end
        tx_data = b;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_res.size() != 0 || exp_frame.size() != 0 || dev_busy) && n < budget) begin
            tick(1);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d results %0d frames pending expected 0", name,
                     exp_res.size(), exp_frame.size());
            exp_res.delete();
            exp_frame.delete();
        end
        tick(3);
        check({name, "_ready"}, 32'(tx_ready), 1);
        check({name, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int n, base;
        tick(5);
        check("reset_ready", 32'(tx_ready), 1);
        check("reset_done", 32'(tx_done), 0);
        check("reset_error", 32'(tx_error), 0);
        check("reset_clk_oe", 32'(ps2_clk_oe), 0);
        check("reset_data_oe", 32'(ps2_data_oe), 0);
        check("reset_busy", 32'(busy), 0);
        reset = 1'b0;
        tick(3);

        // F4: d0..d7 = 0,0,1,0,1,1,1,1, parity 0, stop 1
        send(CMD_ENABLE, 10'h2F4, 1, R_DONE);
        tick(1);
        check("clk_oe_one_cycle_after_accept", 32'(ps2_clk_oe), 1);
        check("busy_after_accept", 32'(busy), 1);
        drain("f4", 5000);
        send(CMD_RESET, 10'h3FF, 1, R_DONE);
        drain("ff", 5000);
        send(8'h00, 10'h300, 1, R_DONE);
        drain("zero", 5000);

        // device never clocks
        mode = M_NOCLK;
        chk_to = 1'b1;
        send(CMD_ENABLE, 10'h0, 0, R_ERR);
        drain("noclk", 20000);
        chk_to = 1'b0;

        // device never ACKs
        mode = M_NOACK;
        send(CMD_ENABLE, 10'h2F4, TRIES, R_ERR);
        drain("noack", 10000);

        // reset after the fourth clock fall
        mode = M_ABORT;
        dev_falls = 0;
        send(CMD_ENABLE, 10'h0, 0, 0);
        n = 0;
        while (dev_falls != 4 && n < 3000) begin
            tick(1);
            n++;
        end
        check("abort_reached_fall4", dev_falls, 4);
        tick(20);
        check("abort_busy_before_reset", 32'(busy), 1);
        reset = 1'b1;
        tick(1);
        check("abort_oes_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
        reset = 1'b0;
        drain("abort", 2000);
        mode = M_NORMAL;
        send(CMD_ENABLE, 10'h2F4, 1, R_DONE);
        drain("after_abort", 5000);

        // tx_valid held through two frames
        base = accepts;
        exp_frame.push_back(10'h312);
        exp_frame.push_back(10'h312);
        exp_res.push_back(R_DONE);
        exp_res.push_back(R_DONE);
        tx_data = 8'h12;
        tx_valid = 1'b1;
        n = 0;
        while (accepts < base + 2 && n < 6000) begin
            tick(1);
            n++;
        end
        tx_valid = 1'b0;
        drain("held", 5000);
        check("held_accepts", accepts - base, 2);

        // 3-cycle clock glitch must not advance a bit
        mode = M_GLITCH;
        send(8'h5A, 10'h35A, 1, R_DONE);
        drain("glitch", 5000);
        mode = M_NORMAL;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
